// File: rtl/spe_packet_tx.sv
// SPE input-packet transmitter: partial-sum FIFO plus timestep/vmem requests, sent over a 4-phase req/ack link.
// Optional SPE_TX_ACK_SYNC_EN: pass out_ack through a 2-flop synchronizer.
module spe_packet_tx #(
  parameter int PE_ID      = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             psum_valid,
  input  logic [24:0]      psum_data,
  output logic             psum_ready,
  input  logic             ts_valid,
  output logic             ts_ready,
  input  logic             vmem_valid,
  input  logic [24:0]      vmem_data,
  output logic             vmem_ready,
  output logic             out_req,
  input  logic             out_ack,
  output logic [32:0]      out_data,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] ADDR = 4'(PE_ID);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT_HI, WAIT_LO} state_t;
  state_t state, state_nxt;

  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcnt;
  logic          full, empty, push, pop;
  logic          ts_pend, vmem_pend, ts_clr, vmem_clr, load;
  logic [24:0]   vmem_hold;
  logic [32:0]   sel_pkt;
  logic          ack_s;

`ifdef SPE_TX_ACK_SYNC_EN
  logic [1:0] ack_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[0], out_ack};
  assign ack_s = ack_sync[1];
`else
  assign ack_s = out_ack;
`endif

  assign full       = (fcnt == (AW+1)'(FIFO_DEPTH));
  assign empty      = (fcnt == '0);
  // ts_pend blocks psums so next-timestep sums can never overtake the flag
  assign psum_ready = !full && !ts_pend;
  assign ts_ready   = !ts_pend;
  assign vmem_ready = !vmem_pend;
  assign push       = psum_valid && psum_ready;
  assign busy       = !empty || ts_pend || vmem_pend || (state != IDLE);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= psum_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fcnt <= fcnt + (AW+1)'(push) - (AW+1)'(pop);
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts_pend   <= 1'b0;
      vmem_pend <= 1'b0;
      vmem_hold <= '0;
    end else begin
      if (ts_valid && !ts_pend) ts_pend <= 1'b1;
      else if (ts_clr)          ts_pend <= 1'b0;
      if (vmem_valid && !vmem_pend) begin
        vmem_pend <= 1'b1;
        vmem_hold <= vmem_data;
      end else if (vmem_clr) vmem_pend <= 1'b0;
    end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    ts_clr    = 1'b0;
    vmem_clr  = 1'b0;
    sel_pkt   = '0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load = 1'b1; pop = 1'b1;
          sel_pkt = {ADDR, 4'd0, mem[rd_ptr]};
        end else if (ts_pend) begin
          load = 1'b1; ts_clr = 1'b1;
          sel_pkt = {ADDR, 4'd1, 25'd0};
        end else if (vmem_pend) begin
          load = 1'b1; vmem_clr = 1'b1;
          sel_pkt = {ADDR, 4'd2, vmem_hold};
        end
        if (load) state_nxt = SETUP;
      end
      SETUP:   state_nxt = WAIT_HI;
      WAIT_HI: if (ack_s)  state_nxt = WAIT_LO;
      WAIT_LO: if (!ack_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      out_req   <= 1'b0;
      out_data  <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_nxt;
      if (load)                       out_data  <= sel_pkt;
      if (state == SETUP)             out_req   <= 1'b1;
      if (state == WAIT_HI && ack_s)  out_req   <= 1'b0;
      if (state == WAIT_LO && !ack_s) pkt_count <= pkt_count + 1'b1;
    end
endmodule

// File: tb/tb_spe_packet_tx.sv
// Scoreboard bench for spe_packet_tx: expected packets queued at acceptance, checked at each out_req rise.
module tb_spe_packet_tx;
  localparam int PE = 3;
  localparam int DEPTH = 4;

  logic        clk = 0, rst_n = 0;
  logic        psum_valid = 0, ts_valid = 0, vmem_valid = 0, out_ack = 0;
  logic [24:0] psum_data = '0, vmem_data = '0;
  logic        psum_ready, ts_ready, vmem_ready, out_req, busy;
  logic [32:0] out_data;
  logic [15:0] pkt_count;

  spe_packet_tx #(.PE_ID(PE), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .psum_valid(psum_valid), .psum_data(psum_data), .psum_ready(psum_ready),
    .ts_valid(ts_valid), .ts_ready(ts_ready),
    .vmem_valid(vmem_valid), .vmem_data(vmem_data), .vmem_ready(vmem_ready),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
    .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int vec = 0, errs = 0;
  logic [32:0] sb[$];
  logic        stall = 0;

  function automatic logic [32:0] pkt(input logic [3:0] op, input logic [24:0] d);
    return {4'(PE), op, d};
  endfunction

  // responder: ack two negedges after req seen, drop when req drops
  int lat = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      out_ack = 0; lat = 0;
    end else if (out_req && !out_ack && !stall) begin
      lat = lat + 1;
      if (lat >= 2) begin out_ack = 1; lat = 0; end
    end else if (!out_req && out_ack) begin
      out_ack = 0;
    end
  end

  // monitor: pop on req rise, data must hold while req high
  logic        prev_req = 0;
  logic [32:0] held = '0;
  always @(negedge clk) begin
    if (out_req && !prev_req) begin
      vec++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL pkt_unexpected: got %h, none queued", out_data);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if (out_data !== e) begin
          errs++;
          $display("FAIL pkt_data: got %h, want %h", out_data, e);
        end
      end
      held = out_data;
    end else if (out_req && prev_req) begin
      vec++;
      if (out_data !== held) begin
        errs++;
        $display("FAIL data_stable: got %h, want %h", out_data, held);
      end
    end
    prev_req = out_req;
  end

  task automatic offer_psum(input logic [24:0] d, input int bound, output bit ok);
    ok = 0;
    psum_valid = 1; psum_data = d;
    for (int i = 0; i < bound; i++) begin
      if (psum_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin sb.push_back(pkt(4'd0, d)); @(negedge clk); end
    psum_valid = 0;
  endtask

  task automatic psum(input logic [24:0] d);
    bit ok;
    offer_psum(d, 300, ok);
    vec++;
    if (!ok) begin errs++; $display("FAIL psum_accept: data %h not accepted, want accepted", d); end
  endtask

  task automatic send_ts();
    bit ok = 0;
    ts_valid = 1;
    for (int i = 0; i < 300; i++) begin
      if (ts_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin sb.push_back(pkt(4'd1, 25'd0)); @(negedge clk); end
    ts_valid = 0;
    vec++;
    if (!ok) begin errs++; $display("FAIL ts_accept: got timeout, want accepted"); end
  endtask

  task automatic send_vmem(input logic [24:0] d);
    bit ok = 0;
    vmem_valid = 1; vmem_data = d;
    for (int i = 0; i < 300; i++) begin
      if (vmem_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin sb.push_back(pkt(4'd2, d)); @(negedge clk); end
    vmem_valid = 0;
    vec++;
    if (!ok) begin errs++; $display("FAIL vmem_accept: got timeout, want accepted"); end
  endtask

  task automatic wait_req();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_req) begin ok = 1; break; end
      @(negedge clk);
    end
    vec++;
    if (!ok) begin errs++; $display("FAIL wait_req: got out_req=0, want 1"); end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy && !out_req && !out_ack && sb.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    vec++;
    if (!ok) begin errs++; $display("FAIL drain: got %0d packets pending busy=%b, want 0", sb.size(), busy); end
  endtask

  task automatic test_reset();
    vec++;
    if ({out_req, out_data, busy, pkt_count} !== {1'b0, 33'h0, 1'b0, 16'h0}) begin
      errs++;
      $display("FAIL reset_state: got req=%b data=%h busy=%b cnt=%0d, want 0/0/0/0", out_req, out_data, busy, pkt_count);
    end
    vec++;
    if ({psum_ready, ts_ready, vmem_ready} !== 3'b111) begin
      errs++; $display("FAIL reset_ready: got %b, want 111", {psum_ready, ts_ready, vmem_ready});
    end
  endtask

  task automatic test_sequence();
    for (int i = 0; i < 5; i++) psum(25'(i));
    send_ts();
    for (int i = 0; i < 5; i++) psum(25'(i));
    send_vmem(25'd60);
    wait_idle();
    vec++;
    if (pkt_count !== 16'd12) begin errs++; $display("FAIL seq_count: got %0d, want 12", pkt_count); end
  endtask

  task automatic test_max_data();
    psum(25'h1FFFFFF);
    wait_req();
    vec++;
    if (out_data !== 33'h061FFFFFF) begin errs++; $display("FAIL max_data: got %h, want 061ffffff", out_data); end
    wait_idle();
  endtask

  task automatic test_full();
    bit ok;
    logic [15:0] c;
    stall = 1;
    send_vmem(25'h155);
    wait_req();
    for (int i = 0; i < DEPTH; i++) psum(25'h100 + 25'(i));
    offer_psum(25'h1AA, 10, ok);
    vec++;
    if (ok) begin errs++; $display("FAIL full_block: got accepted, want psum_ready=0"); end
    vec++;
    if (psum_ready !== 1'b0) begin errs++; $display("FAIL full_ready: got %b, want 0", psum_ready); end
    c = pkt_count;
    stall = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pkt_count != c) begin ok = 1; break; end
    end
    @(negedge clk);
    vec++;
    if (!ok || psum_ready !== 1'b1) begin
      errs++; $display("FAIL full_release: got done=%b ready=%b, want 1/1", ok, psum_ready);
    end
    wait_idle();
  endtask

  task automatic test_ts_block();
    bit ok = 0, blocked = 1;
    stall = 1;
    psum(25'h0A0);
    wait_req();
    for (int i = 1; i <= 3; i++) psum(25'h0A0 + 25'(i));
    send_ts();
    psum_valid = 1; psum_data = 25'h0BB;
    for (int i = 0; i < 5; i++) begin
      if (psum_ready) blocked = 0;
      @(negedge clk);
    end
    vec++;
    if (!blocked) begin errs++; $display("FAIL ts_block: got psum_ready=1, want 0 while ts pending"); end
    stall = 0;
    for (int i = 0; i < 200; i++) begin
      if (psum_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    vec++;
    if (!ok || out_data[28:25] !== 4'd1) begin
      errs++; $display("FAIL ts_unblock: got ready=%b opcode=%0d, want 1/1", ok, out_data[28:25]);
    end
    if (ok) begin sb.push_back(pkt(4'd0, 25'h0BB)); @(negedge clk); end
    psum_valid = 0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    stall = 1;
    psum(25'h0AB);
    wait_req();
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    vec++;
    if (out_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %b, want 0", out_req); end
    @(negedge clk);
    stall = 0;
    rst_n = 1;
    @(negedge clk);
    vec++;
    if ({out_data, busy, pkt_count, psum_ready, ts_ready, vmem_ready} !== {33'h0, 1'b0, 16'h0, 3'b111}) begin
      errs++;
      $display("FAIL rst_state: got data=%h busy=%b cnt=%0d rdy=%b, want 0/0/0/111",
               out_data, busy, pkt_count, {psum_ready, ts_ready, vmem_ready});
    end
    psum(25'h055);
    wait_idle();
    vec++;
    if (pkt_count !== 16'd1) begin errs++; $display("FAIL rst_recover: got %0d, want 1", pkt_count); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_max_data();
    test_full();
    test_ts_block();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
